// File: rtl/dmi_req_arbiter_pkg.sv
// Shared types for the two-port DMI request arbiter.
// Ops, response codes, arbiter states and request/response bundles.
package dmi_arb_pkg;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    localparam logic [1:0] DMINoError = 2'd0;
    localparam logic [1:0] DMIFailed  = 2'd2;
    localparam logic [1:0] DMIBusy    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } arb_state_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_req_arbiter_if.sv
// Requester-side and downstream-side DMI signals of the arbiter.
// slave: the arbiter itself; master: whatever drives it.
interface dmi_req_arbiter_if;

    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][6:0]  req_addr_i;
    logic [1:0][1:0]  req_op_i;
    logic [1:0][31:0] req_data_i;
    logic [1:0]       resp_valid_o;
    logic [1:0]       resp_ready_i;
    logic [31:0]      resp_data_o;
    logic [1:0]       resp_resp_o;
    logic             dmi_req_valid_o;
    logic             dmi_req_ready_i;
    logic [6:0]       dmi_req_addr_o;
    logic [1:0]       dmi_req_op_o;
    logic [31:0]      dmi_req_data_o;
    logic             dmi_resp_valid_i;
    logic             dmi_resp_ready_o;
    logic [31:0]      dmi_resp_data_i;
    logic [1:0]       dmi_resp_resp_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_op_i, req_data_i,
        input  resp_ready_i, dmi_req_ready_i,
        input  dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_resp_o,
        output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o,
        output dmi_req_data_o, dmi_resp_ready_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_op_i, req_data_i,
        output resp_ready_i, dmi_req_ready_i,
        output dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_resp_o,
        input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o,
        input  dmi_req_data_o, dmi_resp_ready_o
    );

endinterface

// File: rtl/dmi_req_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie the port that did not win last
// time is chosen; a lone requester always wins.
module dmi_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       rr_last_i,
    output logic       any_o,
    output logic       idx_o
);

    // Winner index from the current requests and the last winner
    always_comb begin
        any_o = |valid_i;
        idx_o = 1'b0;
        if (&valid_i) begin
            idx_o = ~rr_last_i;
        end else begin
            idx_o = ~valid_i[0];
        end
    end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI target between the JTAG DTM (port 0) and a second master.
// Optional response watchdog enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_req_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            tck_i,
    input  logic            trst_ni,
    dmi_req_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_last_q, rr_last_d;
    dmi_req_t   req_q, req_d;
    dmi_resp_t  rsp_q, rsp_d;
    logic       pick_any;
    logic       pick_idx;

    logic unused_codes;
    assign unused_codes = ^{DMIFailed, DMIBusy};

    dmi_rr_pick u_pick (
        .valid_i   (bus.req_valid_i),
        .rr_last_i (rr_last_q),
        .any_o     (pick_any),
        .idx_o     (pick_idx)
    );

`ifdef DMI_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain_q, drain_d;
    logic             timeout;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
`endif

    // Next-state, latched-field and handshake output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        req_d     = req_q;
        rsp_d     = rsp_q;
        bus.req_ready_o      = '0;
        bus.resp_valid_o     = '0;
        bus.dmi_req_valid_o  = 1'b0;
        bus.dmi_resp_ready_o = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        drain_d = drain_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    bus.req_ready_o[pick_idx] = 1'b1;
                    req_d.addr = bus.req_addr_i[pick_idx];
                    req_d.op   = dtm_op_e'(bus.req_op_i[pick_idx]);
                    req_d.data = bus.req_data_i[pick_idx];
                    grant_d    = pick_idx;
                    rr_last_d  = pick_idx;
                    state_d    = REQ;
`ifdef DMI_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    drain_d = 1'b0;
`endif
                end
            end
            REQ: begin
                bus.dmi_req_valid_o = 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (bus.dmi_req_ready_i) begin
                    state_d = WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
                end else if (timeout) begin
                    rsp_d   = '{data: '0, resp: DMIBusy};
                    drain_d = 1'b0;
                    state_d = RESP;
`endif
                end
            end
            WAIT: begin
                bus.dmi_resp_ready_o = 1'b1;
`ifdef DMI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (bus.dmi_resp_valid_i) begin
                    rsp_d.data = bus.dmi_resp_data_i;
                    rsp_d.resp = bus.dmi_resp_resp_i;
                    state_d    = RESP;
`ifdef DMI_ARB_TIMEOUT_EN
                end else if (timeout) begin
                    rsp_d   = '{data: '0, resp: DMIBusy};
                    drain_d = 1'b1;
                    state_d = RESP;
`endif
                end
            end
            RESP: begin
                bus.resp_valid_o[grant_q] = 1'b1;
                if (bus.resp_ready_i[grant_q]) begin
`ifdef DMI_ARB_TIMEOUT_EN
                    state_d = drain_q ? DRAIN : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef DMI_ARB_TIMEOUT_EN
            DRAIN: begin
                bus.dmi_resp_ready_o = 1'b1;
                if (bus.dmi_resp_valid_i) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction registers
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            req_q     <= '{addr: '0, op: DTM_NOP, data: '0};
            rsp_q     <= '{data: '0, resp: DMINoError};
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            req_q     <= req_d;
            rsp_q     <= rsp_d;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    // Watchdog counter and post-timeout drain flag
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end
`endif

    assign bus.dmi_req_addr_o = req_q.addr;
    assign bus.dmi_req_op_o   = req_q.op;
    assign bus.dmi_req_data_o = req_q.data;
    assign bus.resp_data_o    = rsp_q.data;
    assign bus.resp_resp_o    = rsp_q.resp;

endmodule

// File: doc/dmi_req_arbiter.md
Name: dmi_req_arbiter

Overview:
- Shares one Debug Module Interface (DMI) target port between two requesters: port 0 is the JTAG DTM and port 1 is the secondary debug master (e.g. a trace/SBA bridge).
- Allows one outstanding transaction at a time; the response is always routed back to the port that was granted.
- Sits between the DTM's dr/state/address/data/error register block and the debug module.
- Grants alternate round-robin, with an optional response timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles to wait for the downstream response before aborting (used only with the optional feature).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
- tck_i  in  1  DMI clock.
- trst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  2  per-port request valid.
- req_ready_o  out  2  per-port request accepted.
- req_addr_i  in  2x7  per-port DMI address.
- req_op_i  in  2x2  per-port op: 0 NOP, 1 read, 2 write.
- req_data_i  in  2x32  per-port write data.
- resp_valid_o  out  2  per-port response valid.
- resp_ready_i  in  2  per-port response ready.
- resp_data_o  out  32  response data, shared and qualified by resp_valid_o.
- resp_resp_o  out  2  response code: 0 success, 2 failed, 3 busy.
- dmi_req_valid_o  out  1  downstream request valid.
- dmi_req_ready_i  in  1  downstream request ready.
- dmi_req_addr_o  out  7  downstream address.
- dmi_req_op_o  out  2  downstream op.
- dmi_req_data_o  out  32  downstream write data.
- dmi_resp_valid_i  in  1  downstream response valid.
- dmi_resp_ready_o  out  1  downstream response ready.
- dmi_resp_data_i  in  32  downstream response data.
- dmi_resp_resp_i  in  2  downstream response code.

Behaviour:
- Clock and reset: single clock tck_i; reset is asynchronous, active-low on trst_ni. All state is reset.
- Reset values:
  - Registered state: state=IDLE, grant=0, rr_last=1 (port 0 wins first), latched addr/op/data=0, resp data=0, resp code=0, counter=0.
  - Resulting outputs: all valids/readys low, all buses 0.
- IDLE:
  - If any req_valid_i is set, pick a winner by round-robin: the port not equal to rr_last wins ties; a single requester always wins.
  - Pulse req_ready_o[winner] for one cycle, latch addr/op/data, set grant=winner and rr_last=winner, go to REQ.
  - Acceptance takes one cycle; the request is registered, not combinational.
- REQ:
  - dmi_req_valid_o=1, driving the latched fields, which stay stable while valid.
  - On dmi_req_ready_i, go to WAIT.
- WAIT:
  - dmi_resp_ready_o=1.
  - On dmi_resp_valid_i, latch data/code and go to RESP.
- RESP:
  - resp_valid_o[grant]=1; the other bit stays 0.
  - On resp_ready_i[grant], go to IDLE.
  - A new grant may be issued the cycle after returning to IDLE; minimum 4 cycles per transaction.
- req_ready_o is never asserted outside the IDLE grant cycle. Requests arriving while busy are held by the requester.
- NOP ops are forwarded unchanged; no special-casing.
- Reset mid-transaction: returns to IDLE immediately and drops any in-flight response. The downstream target is reset by the same trst_ni.
- Simultaneous resp_ready_i on the non-granted port is ignored.

Optional Feature:
- Macro: DMI_ARB_TIMEOUT_EN.
- When defined:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES, the arbiter responds with resp code 3 (busy) and data 0.
  - If the timeout occurred in WAIT, the next state after RESP is DRAIN. DRAIN holds dmi_resp_ready_o=1, discards one dmi_resp_valid_i, then goes to IDLE with no grants meanwhile.
  - If the timeout occurred in REQ, dmi_req_valid_o drops (an accepted protocol deviation) and the next state is IDLE.
- When undefined: no counter, no DRAIN state, and the arbiter waits indefinitely.

Decomposition:
- Package dmi_arb_pkg holds:
  - dtm_op_e (NOP/READ/WRITE).
  - DMI response codes (DMINoError=0, DMIFailed=2, DMIBusy=3).
  - The state enum (IDLE, REQ, WAIT, RESP, DRAIN).
  - The dmi_req_t/dmi_resp_t structs.
- One sub-module, dmi_rr_pick: a 2-way round-robin picker, combinational, with rr_last as input. Everything else stays in the top.

Test Plan:
- Port 0 reads addr 0x11 with downstream response data 0xDEADBEEF, code 0 → resp_valid_o=2'b01, resp_data_o=0xDEADBEEF, resp_resp_o=0, req_ready_o[1] never high.
- Both ports request in the same cycle right after reset → port 0 granted first, port 1 next; repeating both yields an alternating 0,1,0,1 grant order.
- Port 1 writes 0x12345678 to 0x10 while dmi_req_ready_i is held low for 5 cycles → dmi_req_* stays stable for all 5 cycles, with exactly one downstream handshake.
- Port 0 holds resp_ready_i low for 3 cycles → resp_valid_o[0] stays high with stable data, port 1's request is not accepted until the cycle after port 0's response handshake.
- trst_ni asserted in WAIT → all outputs 0 immediately; after release, port 0 wins the first request.
- With DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no downstream response → resp code 3 after 8 cycles; a late dmi_resp_valid_i is consumed in DRAIN and never reaches either port.
